// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the mips_sopc core.
// Holds opcode/funct encodings, the ALU-op enum, the NOP word and the
// register-address / data-word types used by every rtl/ file.
package mips_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_MOVZ = 6'h0A;
    localparam logic [5:0] FN_MOVN = 6'h0B;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MTLO = 6'h13;
    localparam logic [5:0] FN_OR   = 6'h25;

    localparam word_t NOP = 32'h0000_0000;

    // LUI and ORI both reduce to ALU_OR with a prepared operand pair.
    typedef enum logic [2:0] {
        ALU_NOP  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_MOVZ = 3'd2,
        ALU_MOVN = 3'd3,
        ALU_MFHI = 3'd4,
        ALU_MTHI = 3'd5,
        ALU_MFLO = 3'd6,
        ALU_MTLO = 3'd7
    } alu_op_t;

endpackage

// File: rtl/cpu.sv
// cpu: 5-stage in-order MIPS32 subset core (IF, ID, EX, MEM, WB).
// Ports: clk_i, rst_ni (async active-low), imem_addr_o (word index),
//        imem_data_i (instruction word).
// No branches and no stalls: every hazard is covered by forwarding.
// Build option SOPC_HILO_EN adds HI/LO with MFHI/MTHI/MFLO/MTLO; without it
// those functs decode as NOP and no HI/LO hardware exists.
module cpu
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [29:0] imem_addr_o,
    input  word_t       imem_data_i
);

    word_t     pc_q;
    word_t     if_id_instr_q;

    reg_addr_t id_rs_s, id_rt_s, id_rd_s;
    word_t     rf_rdata1_s, rf_rdata2_s, rs_val_s, rt_val_s;
    alu_op_t   id_op_s;
    word_t     id_a_s, id_b_s;
    reg_addr_t id_waddr_s;
    logic      id_we_s;

    alu_op_t   ex_op_q;
    word_t     ex_a_q, ex_b_q;
    reg_addr_t ex_waddr_q;
    logic      ex_we_q;
    logic      ex_we_s;
    word_t     ex_wdata_s;

    logic      mem_we_q, wb_we_q;
    reg_addr_t mem_waddr_q, wb_waddr_q;
    word_t     mem_wdata_q, wb_wdata_q;

    logic      unused_bits_s;
`ifdef SOPC_HILO_EN
    logic      ex_hi_we_s, ex_lo_we_s, mem_hi_we_q, mem_lo_we_q, wb_hi_we_q, wb_lo_we_q;
    word_t     hi_q, lo_q, hi_fwd_s, lo_fwd_s;
`endif

    assign imem_addr_o   = pc_q[31:2];
    assign unused_bits_s = ^{pc_q[1:0], if_id_instr_q[10:6]};

    // IF: fetch and advance the PC every cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= 32'h0000_0000;
            if_id_instr_q <= NOP;
        end else begin
            pc_q          <= pc_q + 32'd4;
            if_id_instr_q <= imem_data_i;
        end
    end

    assign id_rs_s = if_id_instr_q[25:21];
    assign id_rt_s = if_id_instr_q[20:16];
    assign id_rd_s = if_id_instr_q[15:11];

    regfile register (
        .clk_i    (clk_i),
        .we_i     (wb_we_q),
        .waddr_i  (wb_waddr_q),
        .wdata_i  (wb_wdata_q),
        .raddr1_i (id_rs_s),
        .rdata1_o (rf_rdata1_s),
        .raddr2_i (id_rt_s),
        .rdata2_o (rf_rdata2_s)
    );

    // Write enables are only ever set for a non-zero destination, so the
    // bypass needs no separate $0 check. The WB leg gives write-through.
    assign rs_val_s = (ex_we_s  && (ex_waddr_q  == id_rs_s)) ? ex_wdata_s  :
                      (mem_we_q && (mem_waddr_q == id_rs_s)) ? mem_wdata_q :
                      (wb_we_q  && (wb_waddr_q  == id_rs_s)) ? wb_wdata_q  : rf_rdata1_s;
    assign rt_val_s = (ex_we_s  && (ex_waddr_q  == id_rt_s)) ? ex_wdata_s  :
                      (mem_we_q && (mem_waddr_q == id_rt_s)) ? mem_wdata_q :
                      (wb_we_q  && (wb_waddr_q  == id_rt_s)) ? wb_wdata_q  : rf_rdata2_s;

    // ID: decode into an ALU op, operand pair and destination
    always_comb begin
        id_op_s    = ALU_NOP;
        id_a_s     = rs_val_s;
        id_b_s     = rt_val_s;
        id_waddr_s = 5'd0;
        case (if_id_instr_q[31:26])
            OP_LUI: begin
                id_op_s    = ALU_OR;
                id_a_s     = 32'h0000_0000;
                id_b_s     = {if_id_instr_q[15:0], 16'h0000};
                id_waddr_s = id_rt_s;
            end
            OP_ORI: begin
                id_op_s    = ALU_OR;
                id_b_s     = {16'h0000, if_id_instr_q[15:0]};
                id_waddr_s = id_rt_s;
            end
            OP_SPECIAL: begin
                case (if_id_instr_q[5:0])
                    FN_OR:   begin id_op_s = ALU_OR;   id_waddr_s = id_rd_s; end
                    FN_MOVZ: begin id_op_s = ALU_MOVZ; id_waddr_s = id_rd_s; end
                    FN_MOVN: begin id_op_s = ALU_MOVN; id_waddr_s = id_rd_s; end
`ifdef SOPC_HILO_EN
                    FN_MFHI: begin id_op_s = ALU_MFHI; id_waddr_s = id_rd_s; end
                    FN_MFLO: begin id_op_s = ALU_MFLO; id_waddr_s = id_rd_s; end
                    FN_MTHI: id_op_s = ALU_MTHI;
                    FN_MTLO: id_op_s = ALU_MTLO;
`endif
                    default: id_op_s = ALU_NOP;
                endcase
            end
            default: id_op_s = ALU_NOP;
        endcase
        id_we_s = (id_waddr_s != 5'd0);
    end

    // ID/EX pipeline register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_op_q    <= ALU_NOP;
            ex_a_q     <= 32'h0000_0000;
            ex_b_q     <= 32'h0000_0000;
            ex_waddr_q <= 5'd0;
            ex_we_q    <= 1'b0;
        end else begin
            ex_op_q    <= id_op_s;
            ex_a_q     <= id_a_s;
            ex_b_q     <= id_b_s;
            ex_waddr_q <= id_waddr_s;
            ex_we_q    <= id_we_s;
        end
    end

`ifdef SOPC_HILO_EN
    assign hi_fwd_s = mem_hi_we_q ? mem_wdata_q : (wb_hi_we_q ? wb_wdata_q : hi_q);
    assign lo_fwd_s = mem_lo_we_q ? mem_wdata_q : (wb_lo_we_q ? wb_wdata_q : lo_q);
`endif

    // EX: compute result; MOVZ/MOVN decide their write enable here so a
    // suppressed move never reaches the bypass network
    always_comb begin
        ex_we_s    = 1'b0;
        ex_wdata_s = ex_a_q | ex_b_q;
`ifdef SOPC_HILO_EN
        ex_hi_we_s = 1'b0;
        ex_lo_we_s = 1'b0;
`endif
        case (ex_op_q)
            ALU_OR:   ex_we_s = ex_we_q;
            ALU_MOVZ: begin ex_we_s = ex_we_q && (ex_b_q == 32'h0000_0000); ex_wdata_s = ex_a_q; end
            ALU_MOVN: begin ex_we_s = ex_we_q && (ex_b_q != 32'h0000_0000); ex_wdata_s = ex_a_q; end
`ifdef SOPC_HILO_EN
            ALU_MFHI: begin ex_we_s = ex_we_q; ex_wdata_s = hi_fwd_s; end
            ALU_MFLO: begin ex_we_s = ex_we_q; ex_wdata_s = lo_fwd_s; end
            ALU_MTHI: begin ex_hi_we_s = 1'b1; ex_wdata_s = ex_a_q; end
            ALU_MTLO: begin ex_lo_we_s = 1'b1; ex_wdata_s = ex_a_q; end
`endif
            default:  ex_we_s = 1'b0;
        endcase
    end

    // EX/MEM and MEM/WB pipeline registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_we_q    <= 1'b0;
            mem_waddr_q <= 5'd0;
            mem_wdata_q <= 32'h0000_0000;
            wb_we_q     <= 1'b0;
            wb_waddr_q  <= 5'd0;
            wb_wdata_q  <= 32'h0000_0000;
`ifdef SOPC_HILO_EN
            mem_hi_we_q <= 1'b0;
            mem_lo_we_q <= 1'b0;
            wb_hi_we_q  <= 1'b0;
            wb_lo_we_q  <= 1'b0;
`endif
        end else begin
            mem_we_q    <= ex_we_s;
            mem_waddr_q <= ex_waddr_q;
            mem_wdata_q <= ex_wdata_s;
            wb_we_q     <= mem_we_q;
            wb_waddr_q  <= mem_waddr_q;
            wb_wdata_q  <= mem_wdata_q;
`ifdef SOPC_HILO_EN
            mem_hi_we_q <= ex_hi_we_s;
            mem_lo_we_q <= ex_lo_we_s;
            wb_hi_we_q  <= mem_hi_we_q;
            wb_lo_we_q  <= mem_lo_we_q;
`endif
        end
    end

`ifdef SOPC_HILO_EN
    // HI/LO commit at WB, cleared by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q <= 32'h0000_0000;
            lo_q <= 32'h0000_0000;
        end else begin
            hi_q <= wb_hi_we_q ? wb_wdata_q : hi_q;
            lo_q <= wb_lo_we_q ? wb_wdata_q : lo_q;
        end
    end
`endif

endmodule

// File: rtl/regfile.sv
// regfile: 32x32 general-purpose register file.
// Ports: clk_i; write port we_i/waddr_i/wdata_i (rising edge);
//        two asynchronous read ports raddr1_i/rdata1_o, raddr2_i/rdata2_o.
// Register 0 always reads zero and is never stored. Contents are not reset.
module regfile
    import mips_pkg::*;
(
    input  logic      clk_i,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  word_t     wdata_i,
    input  reg_addr_t raddr1_i,
    output word_t     rdata1_o,
    input  reg_addr_t raddr2_i,
    output word_t     rdata2_o
);

    word_t storage [0:31];

    // Synchronous write port; writes to $0 are dropped
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != 5'd0)) begin
            storage[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'h0000_0000 : storage[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'h0000_0000 : storage[raddr2_i];

endmodule

// File: rtl/rom.sv
// rom: instruction ROM, filled by the bench before reset release.
// Ports: addr_i (word index), data_o (instruction; NOP when out of range).
module rom
    import mips_pkg::*;
#(
    parameter int ROM_WORDS = 1024
) (
    input  logic [29:0] addr_i,
    output word_t       data_o
);

    localparam int AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;

    word_t storage [0:ROM_WORDS-1];

    assign data_o = (addr_i < 30'(ROM_WORDS)) ? storage[addr_i[AW-1:0]] : NOP;

endmodule

// File: rtl/mips_sopc.sv
// mips_sopc: minimal MIPS32 system-on-chip top level.
// Ports: clock (rising edge), reset (asynchronous, active-low).
// Contains core instance `cpu` and instruction ROM instance `rom`.
// Build option SOPC_HILO_EN enables the HI/LO registers inside the core.
module mips_sopc
    import mips_pkg::*;
#(
    parameter int ROM_WORDS = 1024
) (
    input  logic clock,
    input  logic reset
);

    logic [29:0] rom_addr_s;
    word_t       rom_data_s;

    cpu cpu (
        .clk_i       (clock),
        .rst_ni      (reset),
        .imem_addr_o (rom_addr_s),
        .imem_data_i (rom_data_s)
    );

    rom #(.ROM_WORDS(ROM_WORDS)) rom (
        .addr_i (rom_addr_s),
        .data_o (rom_data_s)
    );

endmodule

// File: tb/tb_mips_sopc.sv
// Self-checking bench for mips_sopc: directed test-plan programs plus
// random programs, checked after every clock edge against an ISA-level
// model that tracks which register values are known.
module tb_mips_sopc;

`ifdef SOPC_HILO_EN
    localparam bit HILO = 1'b1;
`else
    localparam bit HILO = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] prog [$];
    logic [31:0] m_reg [32];
    bit          m_known [32];
    logic [31:0] m_hi, m_lo;
    bit          m_hi_known, m_lo_known;

    mips_sopc #(.ROM_WORDS(1024)) dut (.clock(clock), .reset(reset));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic m_write(input logic [4:0] rd, input logic [31:0] v, input bit k);
        if (rd != 5'd0) begin
            m_reg[rd]   = v;
            m_known[rd] = k;
        end
    endtask

    // Architectural effect of one instruction, straight from the ISA rules
    task automatic model_exec(input logic [31:0] w);
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; imm = w[15:0];
        if (w[31:26] == 6'h0F) m_write(rt, {imm, 16'h0000}, 1'b1);
        else if (w[31:26] == 6'h0D) m_write(rt, m_reg[rs] | {16'h0000, imm}, m_known[rs]);
        else if (w[31:26] == 6'h00) begin
            case (w[5:0])
                6'h25: m_write(rd, m_reg[rs] | m_reg[rt], m_known[rs] && m_known[rt]);
                6'h0A: if (!m_known[rt]) m_write(rd, 32'h0, 1'b0);
                       else if (m_reg[rt] == 32'h0) m_write(rd, m_reg[rs], m_known[rs]);
                6'h0B: if (!m_known[rt]) m_write(rd, 32'h0, 1'b0);
                       else if (m_reg[rt] != 32'h0) m_write(rd, m_reg[rs], m_known[rs]);
                6'h10: if (HILO) m_write(rd, m_hi, m_hi_known);
                6'h12: if (HILO) m_write(rd, m_lo, m_lo_known);
                6'h11: if (HILO) begin m_hi = m_reg[rs]; m_hi_known = m_known[rs]; end
                6'h13: if (HILO) begin m_lo = m_reg[rs]; m_lo_known = m_known[rs]; end
                default: ;
            endcase
        end
    endtask

    task automatic compare_state(input int e);
        for (int r = 1; r < 8; r++) begin
            if (m_known[r]) check_eq($sformatf("r%0d edge%0d", r, e), dut.cpu.register.storage[r], m_reg[r]);
        end
`ifdef SOPC_HILO_EN
        if (m_hi_known) check_eq($sformatf("hi edge%0d", e), dut.cpu.hi_q, m_hi);
        if (m_lo_known) check_eq($sformatf("lo edge%0d", e), dut.cpu.lo_q, m_lo);
`endif
    endtask

    // Drive reset low and check the asynchronous effects before any edge
    task automatic apply_reset(input string tag);
        reset = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0; m_hi_known = 1'b1; m_lo_known = 1'b1;
        #1;
        check_eq({tag, " pc"}, dut.cpu.pc_q, 32'h0);
`ifdef SOPC_HILO_EN
        check_eq({tag, " hi"}, dut.cpu.hi_q, 32'h0);
        check_eq({tag, " lo"}, dut.cpu.lo_q, 32'h0);
`endif
    endtask

    task automatic load_rom();
        for (int i = 0; i < 1024; i++) begin
            dut.rom.storage[i] = (i < prog.size()) ? prog[i] : 32'h0;
        end
    endtask

    // Release reset, then instruction k commits on edge k+5
    task automatic run_prog(input int stop_edge);
        @(negedge clock);
        reset = 1'b1;
        for (int e = 1; e <= prog.size() + 6; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (e >= 5 && (e - 5) < prog.size()) model_exec(prog[e - 5]);
            compare_state(e);
            if (e == stop_edge) begin
                apply_reset("midrun");
                break;
            end
        end
    endtask

    task automatic gen_random(input int n);
        logic [4:0]  a, b, c;
        logic [31:0] w;
        prog.delete();
        for (int i = 0; i < n; i++) begin
            a = 5'($urandom_range(0, 7));
            b = 5'($urandom_range(0, 7));
            c = 5'($urandom_range(0, 7));
            w = $urandom;
            case ($urandom_range(0, 9))
                0: prog.push_back(enc_i(6'h0F, 5'd0, a, w[15:0]));
                1: prog.push_back(enc_i(6'h0D, b, a, w[15:0]));
                2: prog.push_back(enc_r(b, c, a, 6'h25));
                3: prog.push_back(enc_r(b, c, a, 6'h0A));
                4: prog.push_back(enc_r(b, c, a, 6'h0B));
                5: prog.push_back(enc_r(5'd0, 5'd0, a, 6'h10));
                6: prog.push_back(enc_r(b, 5'd0, 5'd0, 6'h11));
                7: prog.push_back(enc_r(5'd0, 5'd0, a, 6'h12));
                8: prog.push_back(enc_r(b, 5'd0, 5'd0, 6'h13));
                default: begin
                    if (w[31:26] == 6'h0F || w[31:26] == 6'h0D) w[31:26] = 6'h3F;
                    if (w[31:26] == 6'h00) w[5:0] = 6'h20;
                    prog.push_back(w);
                end
            endcase
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = 32'h0;
            m_known[r] = (r == 0);
        end
        repeat (3) @(negedge clock);
        apply_reset("por");

        // LUI chain followed by dependent conditional moves
        prog.delete();
        prog.push_back(enc_i(6'h0F, 5'd0, 5'd1, 16'h0000));
        prog.push_back(enc_i(6'h0F, 5'd0, 5'd2, 16'hFFFF));
        prog.push_back(enc_i(6'h0F, 5'd0, 5'd3, 16'h0505));
        prog.push_back(enc_i(6'h0F, 5'd0, 5'd4, 16'h0000));
        prog.push_back(enc_r(5'd2, 5'd1, 5'd4, 6'h0A));
        prog.push_back(enc_r(5'd3, 5'd1, 5'd4, 6'h0B));
        prog.push_back(enc_r(5'd3, 5'd2, 5'd4, 6'h0B));
        prog.push_back(enc_r(5'd2, 5'd3, 5'd4, 6'h0A));
        load_rom();
        run_prog(-1);
        check_eq("lui r1", dut.cpu.register.storage[1], 32'h0000_0000);
        check_eq("lui r2", dut.cpu.register.storage[2], 32'hFFFF_0000);
        check_eq("lui r3", dut.cpu.register.storage[3], 32'h0505_0000);
        check_eq("mov r4", dut.cpu.register.storage[4], 32'h0505_0000);

        // HI then LO path, interrupted once by reset, then rerun from 0
        apply_reset("between");
        prog.delete();
        prog.push_back(enc_r(5'd0, 5'd0, 5'd0, 6'h11));
        prog.push_back(enc_r(5'd2, 5'd0, 5'd0, 6'h11));
        prog.push_back(enc_r(5'd3, 5'd0, 5'd0, 6'h11));
        prog.push_back(enc_r(5'd0, 5'd0, 5'd4, 6'h10));
        prog.push_back(enc_r(5'd3, 5'd0, 5'd0, 6'h13));
        prog.push_back(enc_r(5'd2, 5'd0, 5'd0, 6'h13));
        prog.push_back(enc_r(5'd1, 5'd0, 5'd0, 6'h13));
        prog.push_back(enc_r(5'd0, 5'd0, 5'd4, 6'h12));
        load_rom();
        run_prog(11);
        run_prog(-1);
`ifdef SOPC_HILO_EN
        check_eq("hilo hi", dut.cpu.hi_q, 32'h0505_0000);
        check_eq("hilo lo", dut.cpu.lo_q, 32'h0000_0000);
        check_eq("hilo r4", dut.cpu.register.storage[4], 32'h0000_0000);
`else
        check_eq("hilo r4", dut.cpu.register.storage[4], 32'h0505_0000);
`endif

        // ORI forwarding and writes to $0
        apply_reset("between");
        prog.delete();
        prog.push_back(enc_i(6'h0F, 5'd0, 5'd1, 16'h1234));
        prog.push_back(enc_i(6'h0D, 5'd1, 5'd1, 16'h5678));
        prog.push_back(enc_r(5'd1, 5'd0, 5'd2, 6'h25));
        prog.push_back(enc_i(6'h0D, 5'd0, 5'd0, 16'hFFFF));
        prog.push_back(enc_i(6'h0F, 5'd0, 5'd0, 16'hABCD));
        prog.push_back(enc_r(5'd0, 5'd0, 5'd5, 6'h25));
        load_rom();
        run_prog(-1);
        check_eq("ori r1", dut.cpu.register.storage[1], 32'h1234_5678);
        check_eq("ori r2", dut.cpu.register.storage[2], 32'h1234_5678);
        check_eq("zero r5", dut.cpu.register.storage[5], 32'h0000_0000);

        // Random programs, some cut short by reset and rerun
        for (int p = 0; p < 10; p++) begin
            apply_reset("between");
            gen_random(24);
            load_rom();
            if (p % 2 == 1) run_prog($urandom_range(3, 28));
            run_prog(-1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_sopc.md
# mips_sopc

Minimal MIPS32 system-on-chip: a 5-stage in-order pipelined integer core fetching from an instruction ROM, with a 32×32 register file and HI/LO registers. It is the top-level simulation target for instruction-subset regression. Program images are loaded into the ROM array by the bench before reset release. There is no data memory and no external bus.

## Interface
- ROM_WORDS, 1024: instruction ROM depth in 32-bit words.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; the core runs while high.

## Operation
- Hierarchy is fixed for debug probing:
  - core instance `cpu`;
  - register file instance `cpu.register`, with array `storage[0:31]`;
  - ROM instance `rom`, with array `storage[0:ROM_WORDS-1]`.
- Fetch:
  - the ROM is read combinationally at word index pc[31:2];
  - an out-of-range index returns 32'h0 (NOP);
  - the PC advances by 4 every cycle, with no branches or stalls.
- Supported instructions (standard MIPS32 encodings):
  - LUI (op 0x0F): rt = imm<<16.
  - ORI (op 0x0D): rt = rs | zero-extended imm.
  - SPECIAL (op 0x00) by funct:
    - OR 0x25;
    - MOVZ 0x0A: rd = rs if rt==0, else no write;
    - MOVN 0x0B: rd = rs if rt!=0, else no write;
    - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - Every other encoding, including 0x00000000, executes as NOP: no register and no HI/LO write.
- $0 always reads 0 and writes to it are discarded.
- Register file storage is not reset. Never-written registers hold X.
- HI and LO reset to 0.
- Hazards are fully resolved by forwarding, with no stalls:
  - ID operand reads bypass from EX, MEM and WB results, youngest first;
  - MFHI/MFLO in EX take HI/LO forwarded from MEM and WB.
- For MOVZ/MOVN, the write enable is decided in EX; a suppressed write must not forward.

## Timing
- While reset is low:
  - PC = 0;
  - all pipeline registers hold NOP (write enables clear);
  - HI = LO = 0.
- Stages: IF, ID, EX, MEM, WB. Each pipeline register updates on the rising clock edge.
- Instruction k (byte address 4k) commits to the register file or HI/LO on the (k+5)th rising edge after reset deasserts. The result is visible immediately after that edge.
- A read in ID in the same cycle as a WB write to the same register returns the new value.
- Throughput is one instruction per cycle.
- Reset asserted mid-program:
  - the pipeline is flushed and PC returns to 0;
  - register contents are retained;
  - HI/LO are cleared.

## Configuration
- SOPC_HILO_EN defined: HI/LO registers and MFHI/MTHI/MFLO/MTLO are implemented as above.
- SOPC_HILO_EN undefined:
  - HI/LO and their forwarding paths are not built;
  - those four functs decode as NOP.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct localparams;
  - the ALU-op enum;
  - the NOP constant;
  - reg-address and word typedefs.
- The natural sub-module is `regfile`: 2 asynchronous read ports, 1 synchronous write port, and the $0 rule. It is instantiated as `register` inside `cpu`.
- ROM is a trivial array module instanced as `rom`.

## Test plan
- LUI chain:
  - program: lui $1,0; lui $2,0xFFFF; lui $3,0x0505; lui $4,0;
  - $1..$4 = 0, FFFF0000, 05050000, 0, committed on edges 5, 6, 7, 8 after reset release;
  - before their commit, $2..$4 read X.
- Conditional moves with back-to-back dependencies, following the LUI chain:
  - movz $4,$2,$1 gives $4 = FFFF0000;
  - movn $4,$3,$1 leaves $4 unchanged;
  - movn $4,$3,$2 gives $4 = 05050000;
  - movz $4,$2,$3 leaves $4 unchanged.
- HI path:
  - program: mthi $0; mthi $2; mthi $3; mfhi $4;
  - HI sequence is 0, FFFF0000, 05050000, and $4 = 05050000 via forwarding.
- LO path:
  - program: mtlo $3; mtlo $2; mtlo $1; mflo $4;
  - LO sequence is 05050000, FFFF0000, 0; HI stays 05050000; $4 = 0.
- ORI forwarding: lui $1,0x1234; ori $1,$1,0x5678; or $2,$1,$0 → $2 = 12345678.
- Reset behaviour:
  - reset low mid-run: HI and LO read 0 asynchronously, with no clock edge needed;
  - after release, the program re-executes from address 0;
  - writes to $0 always read back 0.
